// File: rtl/seg7_capture.sv
// seg7_capture
// Captures a seven-segment pattern driven from an asynchronous source,
// waits for it to settle, decodes it to a hex digit and holds the result
// for a ready/valid consumer.
//
// Parameters
//   STABLE_CYCLES  consecutive cycles a new pattern must hold (1..255)
//   ACTIVE_LOW     1: segment inputs are active low, 0: active high
//
// Ports
//   i_clk      single clock, rising edge
//   i_reset_n  asynchronous active-low reset, release synchronized inside
//   i_seg      raw segment lines a..g on bits 0..6, asynchronous to i_clk
//   i_ready    consumer takes the held result when high with o_valid
//   o_valid    a decoded result is held
//   o_val      decoded hex digit
//   o_blank    held result is the all-segments-off pattern
//   o_err      held result is not a recognised glyph
//   o_overrun  one-cycle pulse, an unconsumed result was overwritten
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [6:0] i_seg,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [3:0] o_val,
  output logic       o_blank,
  output logic       o_err,
  output logic       o_overrun
);

  localparam logic [6:0] IdleLevel   = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [7:0] StableCount = 8'(STABLE_CYCLES);

  typedef enum logic {
    ST_WAIT,
    ST_SETTLE
  } state_e;

  logic [1:0] rstSync_q;
  logic       coreRst_n;
  logic [6:0] segSync1_q;
  logic [6:0] segSync2_q;
  logic [6:0] pattern;

  state_e     state_q, state_d;
  logic [6:0] candidate_q, candidate_d;
  logic [7:0] count_q, count_d;
  logic [6:0] accepted_q, accepted_d;
  logic       acceptedValid_q, acceptedValid_d;
  logic       acceptedMatch;
  logic       emit;

  logic       valid_q, valid_d;
  logic [3:0] val_q, val_d;
  logic       blank_q, blank_d;
  logic       err_q, err_d;
  logic       overrun_q, overrun_d;

  logic [3:0] decVal;
  logic       decBlank;
  logic       decErr;

  // Reset asserts everywhere at once but is released to the core logic
  // only after two clock edges, so no register leaves reset on a
  // metastable edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign coreRst_n = rstSync_q[1];

  // Two-flop synchronizer for the segment lines. The reset value is the
  // "all segments off" level, so right after reset the core sees a blank
  // display rather than garbage.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      segSync1_q <= IdleLevel;
      segSync2_q <= IdleLevel;
    end else begin
      segSync1_q <= i_seg;
      segSync2_q <= segSync1_q;
    end
  end

  assign pattern = ACTIVE_LOW ? ~segSync2_q : segSync2_q;

  // After reset no pattern is accepted, so even a blank display counts as
  // new and is reported once it has settled.
  assign acceptedMatch = acceptedValid_q && (pattern == accepted_q);

  // Glyph lookup on the settled candidate. Anything outside the sixteen
  // hex glyphs and the blank pattern is flagged as an error.
  always_comb begin
    decVal   = 4'h0;
    decBlank = 1'b0;
    decErr   = 1'b0;
    unique case (candidate_q)
      7'h3F: decVal = 4'h0;
      7'h06: decVal = 4'h1;
      7'h5B: decVal = 4'h2;
      7'h4F: decVal = 4'h3;
      7'h66: decVal = 4'h4;
      7'h6D: decVal = 4'h5;
      7'h7D: decVal = 4'h6;
      7'h07: decVal = 4'h7;
      7'h7F: decVal = 4'h8;
      7'h6F: decVal = 4'h9;
      7'h77: decVal = 4'hA;
      7'h7C: decVal = 4'hB;
      7'h39: decVal = 4'hC;
      7'h5E: decVal = 4'hD;
      7'h79: decVal = 4'hE;
      7'h71: decVal = 4'hF;
      7'h00: decBlank = 1'b1;
      default: decErr = 1'b1;
    endcase
  end

  // Settling FSM. The count starts at 1 on entry to SETTLE and the result
  // is emitted on the edge after it has reached STABLE_CYCLES, which puts
  // emission 2 + STABLE_CYCLES edges after the first synchronizer capture.
  always_comb begin
    state_d         = state_q;
    candidate_d     = candidate_q;
    count_d         = count_q;
    accepted_d      = accepted_q;
    acceptedValid_d = acceptedValid_q;
    emit            = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        if (!acceptedMatch) begin
          state_d     = ST_SETTLE;
          candidate_d = pattern;
          count_d     = 8'd1;
        end
      end
      ST_SETTLE: begin
        if (acceptedMatch) begin
          state_d = ST_WAIT;
          count_d = 8'd0;
        end else if (pattern == candidate_q) begin
          if (count_q >= StableCount) begin
            emit            = 1'b1;
            accepted_d      = candidate_q;
            acceptedValid_d = 1'b1;
            state_d         = ST_WAIT;
            count_d         = 8'd0;
          end else begin
            count_d = count_q + 8'd1;
          end
        end else begin
          candidate_d = pattern;
          count_d     = 8'd1;
        end
      end
      default: begin
        state_d = ST_WAIT;
        count_d = 8'd0;
      end
    endcase
  end

  // Result holding register. A new emission always wins; it only counts as
  // an overrun when the old result was still held and not being taken on
  // this same edge.
  always_comb begin
    valid_d   = valid_q;
    val_d     = val_q;
    blank_d   = blank_q;
    err_d     = err_q;
    overrun_d = 1'b0;
    if (emit) begin
      valid_d   = 1'b1;
      val_d     = decVal;
      blank_d   = decBlank;
      err_d     = decErr;
      overrun_d = valid_q && !i_ready;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and result registers, cleared by the synchronized core reset so
  // any pending or held result is discarded immediately.
  always_ff @(posedge i_clk or negedge coreRst_n) begin
    if (!coreRst_n) begin
      state_q         <= ST_WAIT;
      candidate_q     <= 7'h00;
      count_q         <= 8'd0;
      accepted_q      <= 7'h00;
      acceptedValid_q <= 1'b0;
      valid_q         <= 1'b0;
      val_q           <= 4'h0;
      blank_q         <= 1'b0;
      err_q           <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      candidate_q     <= candidate_d;
      count_q         <= count_d;
      accepted_q      <= accepted_d;
      acceptedValid_q <= acceptedValid_d;
      valid_q         <= valid_d;
      val_q           <= val_d;
      blank_q         <= blank_d;
      err_q           <= err_d;
      overrun_q       <= overrun_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_val     = val_q;
  assign o_blank   = blank_q;
  assign o_err     = err_q;
  assign o_overrun = overrun_q;

endmodule
